prll_bs_rr_arbiter: RTL and testbench
=====================================

Name: prll_bs_rr_arbiter

Overview:
Round-robin bus controller for the parallel bus shared by `drvrs` driver FIFOs. It selects one pending driver, pops one word from that driver's outgoing FIFO, and pushes the word into the destination driver's incoming FIFO. The destination is encoded in the word's top 8 bits; the `broadcast` ID goes to all other drivers. It sits between the driver FIFOs and the bus and is the only master of pop/push on its bus.

Parameters:
- bits, 32, word width; dest ID = D[bits-1:bits-8]
- drvrs, 2, number of drivers (2..16)
- broadcast, 8'hFF, dest ID meaning "all drivers except source"

Ports:
- clk  in  1  clock
- reset  in  1  reset
- pndng  in  drvrs  driver i outgoing FIFO non-empty
- D_pop  in  drvrs*bits  head word of driver i, slice [i*bits +: bits]; first-word-fall-through, valid while pndng[i]=1
- pop  out  drvrs  one-hot pop strobe to driver i
- push  out  drvrs  push strobe to driver i incoming FIFO
- D_push  out  bits  bus word, common to all drivers
- busy  out  1  transfer in progress (state != IDLE)
- drop_cnt  out  8  count of words with an invalid dest ID (saturating)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: all outputs 0, state=IDLE, last_grant=drvrs-1 (so driver 0 wins first).
- Reset mid-operation: returns to IDLE next edge. No pop/push in that cycle. A word already popped but not pushed is lost.
- All outputs are registered. FSM states:
  - IDLE: if |pndng, grant_q <= rr_pick(pndng, last_grant) → POP; else stay.
  - POP: pop[grant_q]=1 for exactly one cycle; bus_q <= D_pop[grant_q]; → PUSH.
  - PUSH: D_push=bus_q and push asserted for one cycle per the dest rules; last_grant <= grant_q; → IDLE.
- Timing: pndng rising in cycle T produces pop at T+1 and push at T+2. Throughput is one word per 3 cycles.
- D_push holds bus_q outside PUSH.
- Round-robin: the search starts at last_grant+1 modulo drvrs. The first pndng bit found wins. pndng is sampled only in IDLE.
- Dest rules (id = bus_q[bits-1:bits-8]):
  - id == broadcast: push = all ones except bit grant_q.
  - id < drvrs: push = one-hot(id). Self-addressing (id == grant_q) is delivered.
  - Otherwise: push = 0 and drop_cnt increments, saturating at 255.
- Contract: a driver does not deassert pndng or change D_pop between grant and pop. This is not checked.
- busy = 1 in POP and PUSH.

Optional Feature:
- PRLL_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and last_grant is unused.
- Not defined: round-robin as specified above.
- Ports and timing are identical in both builds.

Decomposition:
- Package prll_bus_pkg:
  - state enum {IDLE, POP, PUSH}
  - ID_W=8 constant
  - function id_of(word) returning the top 8 bits
- Sub-module prll_rr_pick: combinational rotate/priority-encode. Inputs req[drvrs] and last[$clog2(drvrs)]; outputs grant index and valid. The macro switches its implementation.

Test Plan:
- Single transfer: drvrs=2, pndng=2'b01, D_pop0=32'h0100_00AA.
  - Required: pop=01 at T+1; push=10 with D_push=32'h0100_00AA at T+2; busy high for 2 cycles.
- Round-robin fairness: pndng=2'b11 held, each driver holding 3 words addressed to the other.
  - Required: grants alternate 0,1,0,1,0,1 with a transfer every 3 cycles.
  - Repeat with PRLL_ARB_FIXED_PRIO_EN: driver 0 drains fully first.
- Broadcast: drvrs=4, driver 2 sends 32'hFF00_1234.
  - Required: push=4'b1011 and D_push=32'hFF00_1234.
- Invalid dest: drvrs=2, word 32'h0500_0000.
  - Required: pop occurs, push=0, drop_cnt 0→1.
  - 300 such words: drop_cnt saturates at 255.
- Reset in POP: assert reset in the pop cycle.
  - Required: the next cycle has pop=0, push=0, busy=0, and the state is IDLE. The next grant goes to driver 0.
- Self-address: driver 1 sends 32'h0100_0055.
  - Required: push=2'b10 and D_push=32'h0100_0055.

Source files
------------

// File: rtl/prll_bs_rr_arbiter_pkg.sv
// prll_bus_pkg: shared FSM states, ID width and dest-ID helper for the parallel bus arbiter
package prll_bus_pkg;
  localparam int ID_W = 8;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {IDLE, POP, PUSH} state_e;
  function automatic logic [ID_W-1:0] id_of(input logic [MAX_W-1:0] word, input int bits);
    return ID_W'(word >> (bits - ID_W));
  endfunction
endpackage

// File: rtl/prll_bs_rr_arbiter_if.sv
// prll_bs_rr_arbiter_if: driver-FIFO side bus of the arbiter; master = arbiter, slave = drivers
interface prll_bs_rr_arbiter_if #(
  parameter int bits = 32,
  parameter int drvrs = 2
);
  logic [drvrs-1:0] pndng;
  logic [drvrs*bits-1:0] D_pop;
  logic [drvrs-1:0] pop;
  logic [drvrs-1:0] push;
  logic [bits-1:0] D_push;
  logic busy;
  logic [7:0] drop_cnt;
  modport master (input pndng, D_pop, output pop, push, D_push, busy, drop_cnt);
  modport slave (output pndng, D_pop, input pop, push, D_push, busy, drop_cnt);
endinterface

// File: rtl/prll_bs_rr_arbiter_rr_pick.sv
// prll_rr_pick: combinational grant picker; round-robin after last, or lowest index wins when PRLL_ARB_FIXED_PRIO_EN is defined
module prll_rr_pick #(
  parameter int drvrs = 2
) (
  input  logic [drvrs-1:0]         req,
  input  logic [$clog2(drvrs)-1:0] last,
  output logic [$clog2(drvrs)-1:0] grant,
  output logic                     valid
);
  localparam int LW = $clog2(drvrs);
  logic [LW-1:0] idx;
`ifdef PRLL_ARB_FIXED_PRIO_EN
  logic unused;
  assign unused = ^last;
  // scan from the top down so the lowest asserted request is the last one written
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx = '0;
    for (int i = drvrs - 1; i >= 0; i--) begin
      idx = LW'(i);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
`else
  // scan offsets last+drvrs down to last+1 so the nearest requester after last is the last one written
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx = '0;
    for (int i = drvrs; i >= 1; i--) begin
      idx = LW'((int'(last) + i) % drvrs);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/prll_bs_rr_arbiter.sv
// prll_bs_rr_arbiter: parallel-bus controller moving one word per 3 cycles from a granted driver FIFO to its destination(s)
module prll_bs_rr_arbiter
  import prll_bus_pkg::*;
#(
  parameter int bits = 32,
  parameter int drvrs = 2,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input logic clk,
  input logic reset,
  prll_bs_rr_arbiter_if.master bus
);
  localparam int LW = $clog2(drvrs);
  state_e state_q, state_d;
  logic [LW-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic pick_v, busy_q, busy_d, bad_id;
  logic [drvrs-1:0] pop_q, pop_d, push_q, push_d;
  logic [bits-1:0] bus_q, bus_d, word;
  logic [ID_W-1:0] id, drop_q, drop_d;
  prll_rr_pick #(.drvrs(drvrs)) u_pick (
    .req  (bus.pndng),
    .last (last_q),
    .grant(pick),
    .valid(pick_v)
  );
  // head word of the granted driver
  always_comb begin
    word = '0;
    for (int i = 0; i < drvrs; i++) if (grant_q == LW'(i)) word = bus.D_pop[i*bits +: bits];
  end
  assign id = id_of(MAX_W'(word), bits);
  assign bad_id = id != broadcast && int'(id) >= drvrs;
  // next-state and registered-output logic; strobes default low so each lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    pop_d = '0;
    push_d = '0;
    bus_d = bus_q;
    drop_d = drop_q;
    if (state_q == IDLE && pick_v) begin
      state_d = POP;
      grant_d = pick;
      pop_d = drvrs'(1) << pick;
    end else if (state_q == POP) begin
      state_d = PUSH;
      bus_d = word;
      push_d = id == broadcast ? ~(drvrs'(1) << grant_q) : bad_id ? '0 : drvrs'(1) << id;
      drop_d = bad_id && drop_q != 8'hFF ? drop_q + 8'd1 : drop_q;
    end else if (state_q == PUSH) begin
      state_d = IDLE;
      last_d = grant_q;
    end
    busy_d = state_d != IDLE;
  end
  // state and output registers; last starts at drvrs-1 so driver 0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= LW'(drvrs - 1);
      pop_q <= '0;
      push_q <= '0;
      bus_q <= '0;
      drop_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      pop_q <= pop_d;
      push_q <= push_d;
      bus_q <= bus_d;
      drop_q <= drop_d;
      busy_q <= busy_d;
    end
  end
  assign bus.pop = pop_q;
  assign bus.push = push_q;
  assign bus.D_push = bus_q;
  assign bus.busy = busy_q;
  assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_prll_bs_rr_arbiter.sv
// tb_prll_bs_rr_arbiter: randomized scoreboard bench for the parallel bus arbiter with queue-based driver FIFOs
module tb_prll_bs_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  prll_bs_rr_arbiter_if #(.bits(W), .drvrs(N)) ifc ();
  prll_bs_rr_arbiter #(.bits(W), .drvrs(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.master)
  );
  typedef struct {
    int src;
    logic [W-1:0] w;
    logic [N-1:0] push;
    logic [7:0] drop;
    bit b2b;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  logic [W-1:0] fifo[N][$];
  logic [N-1:0] popped;
  int n_cmp = 0, n_err = 0, cyc = 0, last_pop = 0, mdl_last = N - 1, mdl_drop = 0;
  bit mon_en = 1'b0, pending = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      ifc.pndng[i] = fifo[i].size() != 0;
      ifc.D_pop[i*W +: W] = fifo[i].size() != 0 ? fifo[i][0] : '0;
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    int r;
    logic [7:0] id;
    r = $urandom_range(0, 7);
    id = r < 6 ? 8'(r) : r == 6 ? 8'hFF : 8'($urandom);
    return {id, 24'($urandom)};
  endfunction

  // reference model: replay the queued words through the arbitration and dest rules
  task automatic plan();
    int k[N];
    int s;
    bit any, first, bad;
    logic [7:0] id;
    logic [N-1:0] pm;
    logic [W-1:0] w;
    first = 1'b1;
    foreach (k[i]) k[i] = 0;
    forever begin
      any = 1'b0;
      s = 0;
`ifdef PRLL_ARB_FIXED_PRIO_EN
      for (int j = 0; j < N; j++) if (k[j] < fifo[j].size()) begin
        s = j;
        any = 1'b1;
        break;
      end
`else
      for (int j = 1; j <= N; j++) begin
        int c;
        c = (mdl_last + j) % N;
        if (k[c] < fifo[c].size()) begin
          s = c;
          any = 1'b1;
          break;
        end
      end
`endif
      if (!any) break;
      mdl_last = s;
      w = fifo[s][k[s]];
      k[s]++;
      id = w[W-1 -: 8];
      bad = id != 8'hFF && int'(id) >= N;
      pm = id == 8'hFF ? ~(N'(1) << s) : bad ? '0 : N'(1) << id;
      if (bad && mdl_drop < 255) mdl_drop++;
      sb.push_back('{src: s, w: w, push: pm, drop: 8'(mdl_drop), b2b: !first});
      first = 1'b0;
    end
  endtask

  task automatic await_batch();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.pop == '0 && n < 10);
    chk("first_pop_latency", n, 1);
    n = 0;
    while ((sb.size() != 0 || pending || ifc.busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("batch_left_unserved", sb.size() + int'(pending), 0);
  endtask

  task automatic go();
    plan();
    refresh();
    await_batch();
  endtask

  // driver FIFOs: drop the head after the edge that consumed it
  initial forever begin
    @(negedge clk);
    popped = ifc.pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (popped[i] && fifo[i].size() != 0) fifo[i].delete(0);
    refresh();
  end

  // monitor: each pop is matched against the next scoreboard entry, its push one cycle later
  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (pending) begin
        chk("push_mask", ifc.push, cur.push);
        chk("d_push", ifc.D_push, cur.w);
        chk("drop_cnt", ifc.drop_cnt, cur.drop);
        chk("busy_in_push", ifc.busy, 1);
        pending = 1'b0;
      end else chk("push_outside_push", ifc.push, 0);
      if (ifc.pop != '0) begin
        if (sb.size() == 0) chk("unexpected_pop", ifc.pop, 0);
        else begin
          cur = sb.pop_front();
          chk("pop_grant", ifc.pop, N'(1) << cur.src);
          chk("busy_in_pop", ifc.busy, 1);
          if (cur.b2b) chk("pop_interval", cyc - last_pop, 3);
          last_pop = cyc;
          pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    refresh();
    repeat (3) @(negedge clk);
    chk("rst_pop", ifc.pop, 0);
    chk("rst_push", ifc.push, 0);
    chk("rst_d_push", ifc.D_push, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_drop", ifc.drop_cnt, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    fifo[0].push_back(32'h0100_00AA);
    go();
    for (int k = 0; k < 3; k++) begin
      fifo[0].push_back({8'h01, 24'($urandom)});
      fifo[1].push_back({8'h00, 24'($urandom)});
    end
    go();
    fifo[2].push_back(32'hFF00_1234);
    go();
    fifo[0].push_back(32'h0500_0000);
    go();
    chk("drop_after_invalid", ifc.drop_cnt, 1);
    fifo[1].push_back(32'h0100_0055);
    go();
    repeat (12) begin
      for (int i = 0; i < N; i++) repeat ($urandom_range(0, 4)) fifo[i].push_back(rand_word());
      if (fifo[0].size() + fifo[1].size() + fifo[2].size() + fifo[3].size() == 0) fifo[3].push_back(rand_word());
      go();
    end
    mon_en = 1'b0;
    fifo[1].push_back(32'h0000_0001);
    fifo[2].push_back(32'h0300_0002);
    refresh();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.pop == '0 && n < 10);
    chk("rstpop_pop_seen", ifc.pop != '0, 1);
    reset = 1'b1;
    fifo[0].push_back(32'h0200_0003);
    @(negedge clk);
    chk("rstpop_pop", ifc.pop, 0);
    chk("rstpop_push", ifc.push, 0);
    chk("rstpop_busy", ifc.busy, 0);
    chk("rstpop_drop", ifc.drop_cnt, 0);
    sb.delete();
    mdl_last = N - 1;
    mdl_drop = 0;
    mon_en = 1'b1;
    plan();
    refresh();
    reset = 1'b0;
    await_batch();
    for (int k = 0; k < 300; k++) fifo[k % N].push_back({8'(5 + k % 3), 24'($urandom)});
    go();
    chk("drop_saturated", ifc.drop_cnt, 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
